// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the MEM-stage load/store port.
// Holds the pipeline with Stall until the access completes, then raises Done for one cycle.
module dmem_responder #(
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              DMemR,
    input  logic              DMemW,
    input  logic [ADDR_W-1:0] DataAdr,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              Stall,
    output logic              Done,
    output logic              AdrErr
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam logic [3:0] LAT = 4'(LATENCY);
    state_t            state, state_nx;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] adr_q, cur_adr;
    logic [31:0]       data_q, cur_data;
    logic              wr_q, cur_wr, req, commit;
    logic [31:0]       mem [DEPTH];
    assign req = DMemR | DMemW;
    // With zero latency the commit edge is the capture edge, so use the live inputs in IDLE.
    assign cur_adr  = (state == IDLE) ? DataAdr : adr_q;
    assign cur_data = (state == IDLE) ? DataIn  : data_q;
    assign cur_wr   = (state == IDLE) ? DMemW   : wr_q;
    assign commit   = (state_nx == RESP) && (cur_adr[1:0] == 2'b00);
    always_comb begin
        state_nx = IDLE;
        state_nx = (state == IDLE) ? (req ? ((LAT != 4'd0) ? WAIT : RESP) : IDLE) :
                   (state == WAIT) ? ((cnt == 4'd1) ? RESP : WAIT) : IDLE;
    end
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            adr_q   <= '0;
            data_q  <= 32'd0;
            wr_q    <= 1'b0;
            DataOut <= 32'd0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req) begin
                adr_q  <= DataAdr;
                data_q <= DataIn;
                wr_q   <= DMemW;
                cnt    <= LAT;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (commit && cur_wr) mem[cur_adr[ADDR_W-1:2]] <= cur_data;
            if (commit && !cur_wr) DataOut <= mem[cur_adr[ADDR_W-1:2]];
        end
    end
    assign Stall  = Reset & req & (state != RESP);
    assign Done   = (state == RESP);
    assign AdrErr = Done & (adr_q[1:0] != 2'b00);
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench; expectations come from a word-array model, a monitor checks each Done.
module tb_dmem_responder;
    localparam int LAT = 2;
    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        dmem_r, dmem_w, stall, done, adr_err;
    logic [7:0]  adr;
    logic [31:0] din, dout;
    logic        z_r, z_w, z_stall, z_done, z_err;
    logic [7:0]  z_adr;
    logic [31:0] z_din, z_dout;

    exp_t        sb[$];
    logic [31:0] ref_mem [64];
    logic [31:0] ref_out;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.ADDR_W(8), .DEPTH(64), .LATENCY(LAT)) u_dut (
        .Clk(clk), .Reset(reset), .DMemR(dmem_r), .DMemW(dmem_w), .DataAdr(adr), .DataIn(din),
        .DataOut(dout), .Stall(stall), .Done(done), .AdrErr(adr_err));

    dmem_responder #(.ADDR_W(8), .DEPTH(64), .LATENCY(0)) u_zero (
        .Clk(clk), .Reset(reset), .DMemR(z_r), .DMemW(z_w), .DataAdr(z_adr), .DataIn(z_din),
        .DataOut(z_dout), .Stall(z_stall), .Done(z_done), .AdrErr(z_err));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (adr_err && !done) chk("adrerr_without_done", 32'(adr_err), 32'd0);
        if (done) begin
            if (sb.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
            else begin
                e = sb.pop_front();
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                chk("dataout", dout, e.data);
                chk("adrerr", 32'(adr_err), 32'(e.err));
            end
        end
    end

    // Called at a falling edge with the DUT idle; returns at the falling edge after Done.
    task automatic issue(input logic r, input logic w, input logic [7:0] a, input logic [31:0] d);
        exp_t e;
        bit   seen = 0;
        dmem_r = r; dmem_w = w; adr = a; din = d;
        e.cyc = cyc + LAT + 1;
        e.err = (a[1:0] != 2'b00);
        if (!e.err && w) ref_mem[a[7:2]] = d;
        else if (!e.err) ref_out = ref_mem[a[7:2]];
        e.data = ref_out;
        sb.push_back(e);
        #1 chk("stall_on_issue", 32'(stall), 32'd1);
        for (int k = 0; k <= LAT + 4; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
            chk("stall_wait", 32'(stall), 32'd1);
        end
        if (!seen) begin
            chk("done_timeout", 32'd0, 32'd1);
            finish_run();
        end
        chk("stall_at_done", 32'(stall), 32'd0);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        dmem_r = 0; dmem_w = 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic zchk(input logic st, input logic dn, input logic [31:0] dv);
        #1;
        chk("z_stall", 32'(z_stall), 32'(st));
        chk("z_done", 32'(z_done), 32'(dn));
        chk("z_dataout", z_dout, dv);
    endtask

    initial begin
        int op, word, off;
        reset = 0; dmem_r = 1; dmem_w = 0; adr = 8'h00; din = 32'd0;
        z_r = 0; z_w = 0; z_adr = 8'h00; z_din = 32'd0;
        ref_out = 32'd0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_adrerr", 32'(adr_err), 32'd0);
        chk("reset_dataout", dout, 32'd0);
        chk("reset_z_dataout", z_dout, 32'd0);
        reset = 1;
        issue(1, 0, 8'h00, 32'd0);
        issue(0, 1, 8'h10, 32'hDEADBEEF);
        issue(1, 0, 8'h10, 32'd0);
        issue(0, 1, 8'h13, 32'h12345678);
        issue(1, 0, 8'h10, 32'd0);
        issue(1, 1, 8'h20, 32'hA5A5A5A5);
        issue(1, 0, 8'h20, 32'd0);
        idle(1);
        // Zero-latency instance: write, then a held read completes every other cycle.
        z_w = 1; z_adr = 8'h24; z_din = 32'hCAFEF00D;
        zchk(1, 0, 32'd0);
        @(negedge clk); zchk(0, 1, 32'd0);
        z_w = 0; z_r = 1;
        @(negedge clk); zchk(1, 0, 32'd0);
        @(negedge clk); zchk(0, 1, 32'hCAFEF00D);
        @(negedge clk); zchk(1, 0, 32'hCAFEF00D);
        @(negedge clk); zchk(0, 1, 32'hCAFEF00D);
        z_adr = 8'h25;
        @(negedge clk); zchk(1, 0, 32'hCAFEF00D);
        @(negedge clk); zchk(0, 1, 32'hCAFEF00D);
        chk("z_adrerr", 32'(z_err), 32'd1);
        z_r = 0;
        @(negedge clk);
        // Abort a write mid-wait with reset; nothing of it may survive.
        dmem_w = 1; dmem_r = 0; adr = 8'h04; din = 32'h11111111;
        @(negedge clk);
        reset = 0;
        #1;
        chk("midreset_stall", 32'(stall), 32'd0);
        chk("midreset_done", 32'(done), 32'd0);
        chk("midreset_dataout", dout, 32'd0);
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'd0;
        ref_out = 32'd0;
        repeat (2) @(negedge clk);
        dmem_w = 0;
        reset = 1;
        idle(LAT + 3);
        issue(1, 0, 8'h04, 32'd0);
        issue(1, 0, 8'h10, 32'd0);
        repeat (80) begin
            op   = $urandom_range(0, 2);
            word = $urandom_range(0, 15);
            off  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
            issue(op != 1, op != 0, 8'(word * 4 + off), $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(LAT + 4);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        finish_run();
    end
endmodule
